// File: rtl/hdb3_loopback_pkg.sv
// Shared definitions for the HDB3 loopback: line symbols, encoder tags, latencies.
package hdb3_loopback_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;

  typedef enum logic [1:0] {
    TAG_ZERO = 2'd0,
    TAG_MARK = 2'd1,
    TAG_V    = 2'd2,
    TAG_B    = 2'd3
  } tag_t;

  localparam int ENC_LATENCY = 5;
  localparam int DEC_LATENCY = 4;

  localparam logic [15:0] P_PATTERN_DEFAULT = 16'b1011_0000_1100_0000;

  function automatic logic [1:0] pol_sym(input logic neg);
    return neg ? SYM_NEG : SYM_POS;
  endfunction

endpackage

// File: rtl/hdb3_decoder.sv
// HDB3 decoder: a bipolar violation wipes the buffered B/0 bits of its substitution group.
module hdb3_decoder
  import hdb3_loopback_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  output logic       o_data
);

  localparam int WIN = DEC_LATENCY - 1;

  logic [WIN-1:0] r_win;
  logic           r_last_neg;
  logic           r_data;
  logic           w_nz;
  logic           w_neg;
  logic           w_is_v;

  // 2'b11 is not a legal symbol and falls through as a zero.
  always_comb begin
    w_nz   = (i_code == SYM_POS) || (i_code == SYM_NEG);
    w_neg  = (i_code == SYM_NEG);
    w_is_v = w_nz && (w_neg == r_last_neg);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win      <= '0;
      r_last_neg <= 1'b1;
      r_data     <= 1'b0;
    end else begin
      if (w_nz) r_last_neg <= w_neg;
      if (w_is_v) begin
        r_win  <= '0;
        r_data <= 1'b0;
      end else begin
        r_win  <= {r_win[WIN-2:0], w_nz};
        r_data <= r_win[WIN-1];
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/hdb3_encoder.sv
// HDB3 encoder: tags bits, delays them so a run's first zero can be retagged B, then applies AMI.
module hdb3_encoder
  import hdb3_loopback_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data,
  output logic [1:0] o_code
);

  localparam int DL_DEPTH = ENC_LATENCY - 1;

  tag_t       r_dl [DL_DEPTH];
  logic [1:0] r_zcnt;
  logic       r_parity;
  logic       r_last_neg;
  logic [1:0] r_code;
  logic       w_fourth;
  tag_t       w_tag_in;
  tag_t       w_tag_out;

  always_comb begin
    w_fourth  = !i_data && (r_zcnt == 2'd3);
    w_tag_out = r_dl[DL_DEPTH-1];
    if (i_data)        w_tag_in = TAG_MARK;
    else if (w_fourth) w_tag_in = TAG_V;
    else               w_tag_in = TAG_ZERO;
  end

  // The first zero of the run sits DL_DEPTH-2 when the V arrives; retag it as it shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DL_DEPTH; i++) r_dl[i] <= TAG_ZERO;
      r_zcnt   <= 2'd0;
      r_parity <= 1'b0;
    end else begin
      r_dl[0] <= w_tag_in;
      for (int i = 1; i < DL_DEPTH - 1; i++) r_dl[i] <= r_dl[i-1];
      r_dl[DL_DEPTH-1] <= (w_fourth && !r_parity) ? TAG_B : r_dl[DL_DEPTH-2];
      r_zcnt   <= (i_data || w_fourth) ? 2'd0 : r_zcnt + 2'd1;
      r_parity <= w_fourth ? 1'b0 : (r_parity ^ i_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_neg <= 1'b1;
      r_code     <= SYM_ZERO;
    end else begin
      case (w_tag_out)
        TAG_MARK, TAG_B: begin
          r_last_neg <= ~r_last_neg;
          r_code     <= pol_sym(~r_last_neg);
        end
        TAG_V:   r_code <= pol_sym(r_last_neg);
        default: r_code <= SYM_ZERO;
      endcase
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/hdb3_pattern_gen.sv
// Cyclic source pattern generator, MSB first, one bit per clock.
module hdb3_pattern_gen
  import hdb3_loopback_pkg::*;
#(
  parameter logic [15:0] P_PATTERN = P_PATTERN_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_data
);

  logic [3:0] r_index;
  logic       r_src;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_index <= 4'd0;
      r_src   <= 1'b0;
    end else begin
      r_src   <= P_PATTERN[4'd15 - r_index];
      r_index <= r_index + 4'd1;
    end
  end

  assign o_data = r_src;

endmodule

// File: rtl/hdb3_loopback.sv
// HDB3 loopback top: pattern generator -> encoder -> decoder.
module hdb3_loopback
  import hdb3_loopback_pkg::*;
#(
  parameter logic [15:0] P_PATTERN = P_PATTERN_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_src_data,
  output logic [1:0] o_hdb3_code,
  output logic       o_data
);

  logic       w_src;
  logic [1:0] w_code;
  logic       w_data;

  hdb3_pattern_gen #(.P_PATTERN(P_PATTERN)) u_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_data  (w_src)
  );

  hdb3_encoder u_enc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (w_src),
    .o_code  (w_code)
  );

  hdb3_decoder u_dec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (w_code),
    .o_data  (w_data)
  );

  assign o_src_data  = w_src;
  assign o_hdb3_code = w_code;
  assign o_data      = w_data;

endmodule

// File: tb/tb_hdb3_loopback.sv
// Self-checking bench for hdb3_loopback: reference HDB3 model feeding code/data scoreboards.
module tb_hdb3_loopback;

  localparam logic [15:0] PAT   = 16'b1011_0000_1100_0000;
  localparam int          N_CYC = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src, data, src_z, data_z, src_a, data_a;
  logic [1:0] code, code_z, code_a;

  always #5 clk = ~clk;

  hdb3_loopback #(.P_PATTERN(PAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_src_data(src), .o_hdb3_code(code), .o_data(data));
  hdb3_loopback #(.P_PATTERN(16'h0000)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .o_src_data(src_z), .o_hdb3_code(code_z), .o_data(data_z));
  hdb3_loopback #(.P_PATTERN(16'b1000_0100_0000_0000)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_src_data(src_a), .o_hdb3_code(code_a), .o_data(data_a));

  int n_checks = 0;
  int n_errors = 0;

  logic       m_src  [N_CYC];
  logic [1:0] m_code [N_CYC];
  logic [1:0] q_code [$];
  logic       q_data [$];

  // Observed-stream line rule tracking
  int zrun, last_pol, last_nonv_pol, last_v_pol;
  bit seen_pulse, have_nonv, have_v;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] sym_of(input int pol);
    return (pol > 0) ? 2'b01 : 2'b10;
  endfunction

  // Reference: stream includes the reset-time zero seen by the encoder at cycle 0.
  task automatic build_model();
    logic [15:0] pat_v;
    int pol, pulses, zc;
    pat_v = PAT;
    pol = -1; pulses = 0; zc = 0;
    for (int i = 0; i < N_CYC; i++) begin
      m_src[i] = (i == 0) ? 1'b0 : pat_v[15 - ((i - 1) % 16)];
      if (m_src[i]) begin
        pol = -pol;
        m_code[i] = sym_of(pol);
        pulses++;
        zc = 0;
      end else begin
        m_code[i] = 2'b00;
        zc++;
        if (zc == 4) begin
          if (pulses % 2 == 0) begin
            pol = -pol;
            m_code[i-3] = sym_of(pol);
          end
          m_code[i] = sym_of(pol);
          pulses = 0;
          zc = 0;
        end
      end
    end
  endtask

  task automatic restart_scoreboard();
    q_code.delete();
    q_data.delete();
    repeat (5) q_code.push_back(2'b00);
    repeat (9) q_data.push_back(1'b0);
    zrun = 0; seen_pulse = 0; have_nonv = 0; have_v = 0;
    last_pol = -1; last_nonv_pol = 0; last_v_pol = 0;
  endtask

  task automatic check_cycle(input int c);
    logic [1:0] exp_c;
    logic       exp_d;
    int         p;
    check_val("src", src, m_src[c]);
    exp_c = q_code.pop_front();
    check_val("code", code, exp_c);
    q_code.push_back(m_code[c]);
    exp_d = q_data.pop_front();
    check_val("loop_data", data, exp_d);
    q_data.push_back(m_src[c]);
    if (code != 2'b00) begin
      p = (code == 2'b01) ? 1 : -1;
      if (seen_pulse) check_val("zero_run_le3", int'(zrun <= 3), 1);
      if (p == last_pol) begin
        if (have_v) check_val("v_alternate", p, -last_v_pol);
        last_v_pol = p;
        have_v = 1;
      end else begin
        if (have_nonv) check_val("ami_alternate", p, -last_nonv_pol);
        last_nonv_pol = p;
        have_nonv = 1;
      end
      last_pol = p;
      seen_pulse = 1;
      zrun = 0;
    end else if (seen_pulse) begin
      zrun++;
    end
  endtask

  logic [1:0] z_exp [8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
  logic [1:0] a_exp [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

  initial begin
    build_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_src", src, 0);
    check_val("rst_code", code, 0);
    check_val("rst_data", data, 0);
    #1 rst_n = 1'b1;
    restart_scoreboard();
    check_cycle(0);
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk);
      #1;
      check_cycle(c);
      if (c >= 5 && c <= 12) check_val("all_zero_b00v", code_z, z_exp[c-5]);
      if (c >= 6 && c <= 11) check_val("single_000v", code_a, a_exp[c-6]);
    end

    // Mid-pattern asynchronous reset pulse spanning one rising edge
    #2 rst_n = 1'b0;
    #1;
    check_val("async_src", src, 0);
    check_val("async_code", code, 0);
    check_val("async_data", data, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    restart_scoreboard();
    check_cycle(0);
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      check_cycle(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
